// File: rtl/rs232_pkg.sv
// rs232_pkg
//   Shared types and constants for the RS-232 stream transmitter (and its
//   future matching receiver).
//   Contents:
//     STREAM_WIDTH  - width of the stb/ack stream word
//     CHAR_WIDTH    - bits per serial character
//     tx_state_e    - transmitter FSM states
//     calc_divisor  - clock cycles per bit, rounded to nearest
package rs232_pkg;

  localparam int STREAM_WIDTH = 32;
  localparam int CHAR_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Rounded rather than truncated so the bit period error stays below half a
  // clock for any clock/baud pair.
  function automatic int calc_divisor(input int clock_frequency, input int baud_rate);
    return (clock_frequency + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// rs232_baud_gen
//   Bit-period timer: counts 0..DIVISOR-1 while enabled and pulses o_bit_tick
//   for one cycle on the count that wraps back to 0.
//   Ports:
//     i_clk       system clock
//     i_rst_n     asynchronous active-low reset
//     i_clr       synchronous clear to 0 (wins over i_en, suppresses tick)
//     i_en        count enable
//     o_bit_tick  high during the last cycle of each bit period
module rs232_baud_gen #(
  parameter int DIVISOR = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap     = (r_cnt == LAST);
  assign o_bit_tick = i_en && !i_clr && w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rs232_tx_sink.sv
// rs232_tx_sink
//   Stream-to-UART transmitter. Accepts 32-bit stb/ack words and sends bits
//   [7:0] as an RS-232 frame (start, 8 data LSB first, [parity], stop).
//   Build option: define RS232_TX_PARITY_EN for 8E1 frames (even parity bit
//   after the data bits); undefined gives plain 8N1.
//   Ports:
//     clk           system clock
//     rst           asynchronous active-low reset
//     input_in      stream data, only [7:0] is sent
//     input_in_stb  producer has a word
//     input_in_ack  sink ready; transfer on an edge with stb && ack
//     tx            serial line, idle high
//     busy          high while a frame is on the line
module rs232_tx_sink
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STREAM_WIDTH-1:0] input_in,
  input  logic                    input_in_stb,
  output logic                    input_in_ack,
  output logic                    tx,
  output logic                    busy
);

  localparam int DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(CHAR_WIDTH - 1);

  tx_state_e             r_state, w_state_nxt;
  logic [CHAR_WIDTH-1:0] r_data, w_data_nxt;
  logic [2:0]            r_bit_idx, w_bit_idx_nxt;
  logic [2:0]            w_bit_idx_inc;
  logic                  r_tx, w_tx_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  w_handshake;
  logic                  w_bit_tick;
  logic                  w_unused_upper;

  // Upper stream bits carry nothing for a character sink.
  assign w_unused_upper = ^input_in[STREAM_WIDTH-1:CHAR_WIDTH];

  assign w_handshake   = (r_state == IDLE) && r_ack && input_in_stb;
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  rs232_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud_gen (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_clr      (w_handshake),
    .i_en       (r_state != IDLE),
    .o_bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // All outputs are registered: next values are decided here so tx changes
  // exactly on the edge that starts each bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_nxt      = r_tx;
    w_ack_nxt     = r_ack;
    w_busy_nxt    = r_busy;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_data_nxt    = input_in[CHAR_WIDTH-1:0];
          w_bit_idx_nxt = '0;
          w_ack_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = START;
        end else begin
          w_ack_nxt = 1'b1;
        end
      end
      START: begin
        if (w_bit_tick) begin
          w_tx_nxt    = r_data[0];
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          if (r_bit_idx == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
            w_tx_nxt    = ^r_data;
            w_state_nxt = PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_idx_nxt = w_bit_idx_inc;
            w_tx_nxt      = r_data[w_bit_idx_inc];
          end
        end
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        if (w_bit_tick) begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        // ack rises on the same edge the frame ends so a held stb can start
        // the next frame one cycle later.
        if (w_bit_tick) begin
          w_busy_nxt  = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_ack_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign input_in_ack = r_ack;
  assign tx           = r_tx;
  assign busy         = r_busy;

endmodule

// File: tb/tb_rs232_tx_sink.sv
// tb_rs232_tx_sink
//   Directed bench for rs232_tx_sink at CLOCK_FREQUENCY=1000, BAUD_RATE=100
//   (10 cycles per bit). Honours RS232_TX_PARITY_EN the same way the RTL does.
module tb_rs232_tx_sink;

  localparam int DIV = 10;
`ifdef RS232_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;
  localparam int FRAME = NBITS * DIV;

  logic        clk;
  logic        rst;
  logic [31:0] input_in;
  logic        input_in_stb;
  logic        input_in_ack;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;

  rs232_tx_sink #(
    .CLOCK_FREQUENCY (1000),
    .BAUD_RATE       (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .input_in     (input_in),
    .input_in_stb (input_in_stb),
    .input_in_ack (input_in_ack),
    .tx           (tx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && input_in_stb && input_in_ack) n_xfer++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PAR && k == 9) return ^d;
    return 1'b1;
  endfunction

  // Waits (bounded) for the falling edge of a start bit; returns on the
  // negedge where tx is first seen low.
  task automatic wait_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check_val({tag, " start seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Called on the negedge of frame cycle 0. Checks every cycle of the frame,
  // then (unless keep_stb) drops stb and checks the idle state right after.
  task automatic capture_frame(input logic [7:0] d, input bit keep_stb, input string tag);
    logic [10:0] mid;
    logic [10:0] exp_pat;
    int tx_bad, busy_lo, ack_hi;
    mid = '0;
    exp_pat = '0;
    tx_bad = 0;
    busy_lo = 0;
    ack_hi = 0;
    for (int k = 0; k < NBITS; k++) exp_pat[k] = exp_bit(d, k);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0 && !keep_stb) input_in_stb = 1'b0;
      if (tx !== exp_bit(d, i / DIV)) tx_bad++;
      if (busy !== 1'b1) busy_lo++;
      if (input_in_ack !== 1'b0) ack_hi++;
      if (i % DIV == DIV / 2) mid[i / DIV] = tx;
    end
    check_val({tag, " bits"}, {21'd0, mid}, {21'd0, exp_pat});
    check_val({tag, " tx cycles wrong"}, tx_bad, 0);
    check_val({tag, " busy low cycles"}, busy_lo, 0);
    check_val({tag, " ack high cycles"}, ack_hi, 0);
    if (!keep_stb) begin
      @(negedge clk);
      check_val({tag, " end busy"}, {31'd0, busy}, 32'd0);
      check_val({tag, " end ack"}, {31'd0, input_in_ack}, 32'd1);
      check_val({tag, " end tx"}, {31'd0, tx}, 32'd1);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input string tag);
    int x0;
    x0 = n_xfer;
    @(negedge clk);
    input_in = w;
    input_in_stb = 1'b1;
    wait_start(tag);
    capture_frame(w[7:0], 1'b0, tag);
    check_val({tag, " transfers"}, n_xfer - x0, 1);
  endtask

  initial begin
    int x0;
    int lows;
    rst = 1'b0;
    input_in = '0;
    input_in_stb = 1'b0;

    // Reset
    repeat (5) @(negedge clk);
    check_val("rst tx", {31'd0, tx}, 32'd1);
    check_val("rst ack", {31'd0, input_in_ack}, 32'd0);
    check_val("rst busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("ack after release", {31'd0, input_in_ack}, 32'd1);
    check_val("idle tx", {31'd0, tx}, 32'd1);

    // Basic frames, upper bits ignored
    send_frame(32'h0000_0055, "0x55");
    send_frame(32'hFFFF_FFA3, "0xA3");

    // Back-to-back with stb held; data changes after the first latch
    x0 = n_xfer;
    @(negedge clk);
    input_in = 32'h0000_0000;
    input_in_stb = 1'b1;
    wait_start("b2b first");
    input_in = 32'h0000_00FF;
    capture_frame(8'h00, 1'b1, "b2b first");
    @(negedge clk);
    check_val("b2b gap tx", {31'd0, tx}, 32'd1);
    check_val("b2b gap ack", {31'd0, input_in_ack}, 32'd1);
    @(negedge clk);
    check_val("b2b second start at +101", {31'd0, tx}, 32'd0);
    capture_frame(8'hFF, 1'b0, "b2b second");
    check_val("b2b transfers", n_xfer - x0, 2);

    // Reset in the middle of data bit 3 of 0x0F
    @(negedge clk);
    input_in = 32'h0000_000F;
    input_in_stb = 1'b1;
    wait_start("rst mid");
    input_in_stb = 1'b0;
    repeat (4 * DIV + 3) @(negedge clk);
    check_val("rst mid bit3 before", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    #1;
    check_val("rst mid tx", {31'd0, tx}, 32'd1);
    check_val("rst mid busy", {31'd0, busy}, 32'd0);
    check_val("rst mid ack", {31'd0, input_in_ack}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check_val("no residue after reset", lows, 0);
    send_frame(32'h0000_003C, "0x3C");

    // Parity-sensitive frames (frame length follows build option)
    send_frame(32'h0000_0007, "0x07");
    send_frame(32'h0000_0003, "0x03");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
